// File: rtl/interrupt_sequencer.sv
// Sequences RESET/NMI/IRQ/BRK entry (dummy reads, three pushes, two vector fetches); one step per ready cycle,
// every output is decoded from registered state; ready=0 freezes state and outputs, no internal buffering.
module interrupt_sequencer #(
    parameter int NMI_SYNC_STAGES = 2,
    parameter int DUMMY_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ready,
    input  logic       instructionBoundary,
    input  logic       brkExecute,
    input  logic       irqN,
    input  logic       nmiN,
    input  logic       resetRequest,
    input  logic       interruptMask,
    output logic       sequenceActive,
    output logic [2:0] sequenceStep,
    output logic [1:0] cause,
    output logic       adhStackPage,
    output logic       adlFromSp,
    output logic       spDecrement,
    output logic [1:0] pushSource,
    output logic       writeCycle,
    output logic [5:0] adlPresetSelect,
    output logic       adhHigh,
    output logic       loadPcl,
    output logic       loadPch,
    output logic       setInterruptFlag,
    output logic       breakBitHigh,
    output logic       sequenceDone
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DUMMY0   = 3'd1,
        ST_DUMMY1   = 3'd2,
        ST_PUSH_PCH = 3'd3,
        ST_PUSH_PCL = 3'd4,
        ST_PUSH_PSR = 3'd5,
        ST_VEC_LO   = 3'd6,
        ST_VEC_HI   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_RESET = 2'd0,
        CAUSE_NMI   = 2'd1,
        CAUSE_IRQ   = 2'd2,
        CAUSE_BRK   = 2'd3
    } cause_t;

    state_t                     state_q, state_d;
    cause_t                     cause_q, cause_d;
    logic                       reset_pending_q, reset_pending_d;
    logic                       nmi_pending_q, nmi_pending_d;
    logic [NMI_SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic                       nmi_prev_q, nmi_prev_d;
    logic                       done_q, done_d;
    logic                       nmi_fall;
    logic                       launch_nmi;
    logic                       in_push;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= ST_IDLE;
            cause_q         <= CAUSE_RESET;
            reset_pending_q <= 1'b1;
            nmi_pending_q   <= 1'b0;
            nmi_sync_q      <= '1;
            nmi_prev_q      <= 1'b1;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cause_q         <= cause_d;
            reset_pending_q <= reset_pending_d;
            nmi_pending_q   <= nmi_pending_d;
            nmi_sync_q      <= nmi_sync_d;
            nmi_prev_q      <= nmi_prev_d;
            done_q          <= done_d;
        end
    end

    // NMI edge detection runs regardless of ready so no edge is lost during a stall.
    always_comb begin
        nmi_sync_d = {nmi_sync_q[NMI_SYNC_STAGES-2:0], nmiN};
        nmi_prev_d = nmi_sync_q[NMI_SYNC_STAGES-1];
        nmi_fall   = nmi_prev_q & ~nmi_sync_q[NMI_SYNC_STAGES-1];
    end

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        reset_pending_d = reset_pending_q;
        done_d          = done_q;
        launch_nmi      = 1'b0;
        if (ready) begin
            done_d = 1'b0;
            if (state_q == ST_IDLE) begin
                if (reset_pending_q || instructionBoundary) begin
                    if (reset_pending_q || resetRequest) begin
                        state_d = ST_DUMMY0;
                        cause_d = CAUSE_RESET;
                    end else if (nmi_pending_q) begin
                        state_d    = ST_DUMMY0;
                        cause_d    = CAUSE_NMI;
                        launch_nmi = 1'b1;
                    end else if (brkExecute) begin
                        state_d = ST_DUMMY0;
                        cause_d = CAUSE_BRK;
                    end else if (!irqN && !interruptMask) begin
                        state_d = ST_DUMMY0;
                        cause_d = CAUSE_IRQ;
                    end
                end
            end else if (resetRequest) begin
                state_d = ST_DUMMY0;
                cause_d = CAUSE_RESET;
            end else begin
                case (state_q)
                    ST_DUMMY0: state_d = (DUMMY_CYCLES == 2) ? ST_DUMMY1 : ST_PUSH_PCH;
                    ST_VEC_HI: begin
                        state_d         = ST_IDLE;
                        reset_pending_d = 1'b0;
                        done_d          = 1'b1;
                    end
                    default:   state_d = state_t'(state_q + 3'd1);
                endcase
            end
        end
        nmi_pending_d = (nmi_pending_q & ~launch_nmi) | nmi_fall;
    end

    always_comb begin
        in_push          = (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) || (state_q == ST_PUSH_PSR);
        sequenceActive   = (state_q != ST_IDLE);
        sequenceStep     = state_q;
        cause            = cause_q;
        sequenceDone     = done_q;
        adhStackPage     = in_push;
        adlFromSp        = in_push;
        spDecrement      = in_push;
        // A reset entry walks the stack addresses but must never write memory.
        writeCycle       = in_push && (cause_q != CAUSE_RESET);
        breakBitHigh     = (state_q == ST_PUSH_PSR) && (cause_q == CAUSE_BRK);
        pushSource       = 2'd0;
        adlPresetSelect  = 6'b000000;
        adhHigh          = (state_q == ST_VEC_LO) || (state_q == ST_VEC_HI);
        loadPcl          = (state_q == ST_VEC_LO);
        loadPch          = (state_q == ST_VEC_HI);
        setInterruptFlag = (state_q == ST_VEC_LO);
        case (state_q)
            ST_PUSH_PCL: pushSource = 2'd1;
            ST_PUSH_PSR: pushSource = 2'd2;
            ST_VEC_LO: begin
                case (cause_q)
                    CAUSE_RESET: adlPresetSelect = 6'b000100;
                    CAUSE_NMI:   adlPresetSelect = 6'b000001;
                    default:     adlPresetSelect = 6'b010000;
                endcase
            end
            ST_VEC_HI: begin
                case (cause_q)
                    CAUSE_RESET: adlPresetSelect = 6'b001000;
                    CAUSE_NMI:   adlPresetSelect = 6'b000010;
                    default:     adlPresetSelect = 6'b100000;
                endcase
            end
            default: pushSource = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed table, corner-case sequences and random traffic against a sequence-level model.
module tb_interrupt_sequencer;

    logic       clk  = 1'b0;
    logic       nrst = 1'b1;
    logic       ready, instructionBoundary, brkExecute, irqN, nmiN, resetRequest, interruptMask;
    logic       sequenceActive, adhStackPage, adlFromSp, spDecrement, writeCycle;
    logic       adhHigh, loadPcl, loadPch, setInterruptFlag, breakBitHigh, sequenceDone;
    logic [2:0] sequenceStep;
    logic [1:0] cause, pushSource;
    logic [5:0] adlPresetSelect;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk(clk), .nrst(nrst), .ready(ready), .instructionBoundary(instructionBoundary),
        .brkExecute(brkExecute), .irqN(irqN), .nmiN(nmiN), .resetRequest(resetRequest),
        .interruptMask(interruptMask), .sequenceActive(sequenceActive), .sequenceStep(sequenceStep),
        .cause(cause), .adhStackPage(adhStackPage), .adlFromSp(adlFromSp), .spDecrement(spDecrement),
        .pushSource(pushSource), .writeCycle(writeCycle), .adlPresetSelect(adlPresetSelect),
        .adhHigh(adhHigh), .loadPcl(loadPcl), .loadPch(loadPch), .setInterruptFlag(setInterruptFlag),
        .breakBitHigh(breakBitHigh), .sequenceDone(sequenceDone)
    );

    typedef struct packed {
        logic       act;
        logic [2:0] step;
        logic [1:0] cause;
        logic       adh_sp, adl_sp, sp_dec;
        logic [1:0] psrc;
        logic       wr;
        logic [5:0] sel;
        logic       adh_hi, ld_pcl, ld_pch, set_i, brk_b, done;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {sequenceActive, sequenceStep, cause, adhStackPage, adlFromSp, spDecrement, pushSource,
                    writeCycle, adlPresetSelect, adhHigh, loadPcl, loadPch, setInterruptFlag, breakBitHigh,
                    sequenceDone};

    typedef struct {
        bit       rdy, bnd, brk, irq, msk, rq;
        bit [2:0] step;
        bit [1:0] cause;
        bit       wr, done;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    // Sequence-level model: which cause is running, where in the step list it is, and pending requests.
    int   seq_steps[$];
    bit   m_active, m_done, m_rst_pend, m_nmi_pend;
    int   m_pos;
    bit [1:0] m_cause;
    bit   nmi_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(bit rdy, bit bnd, bit brk, bit irq, bit msk, bit rq,
                               bit [2:0] step, bit [1:0] c, bit wr, bit done);
        vec_t r;
        r.rdy = rdy; r.bnd = bnd; r.brk = brk; r.irq = irq; r.msk = msk; r.rq = rq;
        r.step = step; r.cause = c; r.wr = wr; r.done = done;
        return r;
    endfunction

    function automatic logic [7:0] vec_base(bit [1:0] c);
        case (c)
            2'd0:    return 8'hFC;
            2'd1:    return 8'hFA;
            default: return 8'hFE;
        endcase
    endfunction

    function automatic outs_t model_outs();
        outs_t      o = '0;
        int         st;
        logic [7:0] va;
        o.cause = m_cause;
        o.done  = m_done;
        if (m_active) begin
            st     = seq_steps[m_pos];
            o.act  = 1'b1;
            o.step = 3'(st);
            if (st >= 3 && st <= 5) begin
                o.adh_sp = 1'b1; o.adl_sp = 1'b1; o.sp_dec = 1'b1;
                o.psrc   = 2'(st - 3);
                o.wr     = (m_cause != 2'd0);
                o.brk_b  = (st == 5) && (m_cause == 2'd3);
            end
            if (st >= 6) begin
                va       = vec_base(m_cause) + 8'(st - 6);
                o.sel    = 6'(1 << (va - 8'hFA));
                o.adh_hi = 1'b1;
                o.ld_pcl = (st == 6);
                o.set_i  = (st == 6);
                o.ld_pch = (st == 7);
            end
        end
        return o;
    endfunction

    task automatic model_start(input bit [1:0] c);
        m_active = 1'b1;
        m_pos    = 0;
        m_cause  = c;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_rst_pend = 1'b1; m_nmi_pend = 1'b0;
        m_pos = 0; m_cause = 2'd0;
        nmi_hist.delete();
        repeat (3) nmi_hist.push_back(1'b1);
    endtask

    task automatic model_edge();
        bit fell;
        bit took_nmi;
        fell     = nmi_hist[0] && !nmi_hist[1];
        took_nmi = 1'b0;
        if (ready) begin
            m_done = 1'b0;
            if (!m_active) begin
                if (m_rst_pend || instructionBoundary) begin
                    if (m_rst_pend || resetRequest)       model_start(2'd0);
                    else if (m_nmi_pend) begin            model_start(2'd1); took_nmi = 1'b1; end
                    else if (brkExecute)                  model_start(2'd3);
                    else if (!irqN && !interruptMask)     model_start(2'd2);
                end
            end else if (resetRequest) begin
                model_start(2'd0);
            end else if (m_pos == seq_steps.size() - 1) begin
                m_active = 1'b0; m_rst_pend = 1'b0; m_done = 1'b1;
            end else begin
                m_pos++;
            end
        end
        if (took_nmi) m_nmi_pend = 1'b0;
        if (fell)     m_nmi_pend = 1'b1;
        void'(nmi_hist.pop_front());
        nmi_hist.push_back(nmiN);
    endtask

    task automatic tick();
        @(posedge clk);
        if (nrst) model_edge();
        #1;
        chk("model_outputs", 32'(dut_o), 32'(model_outs()));
    endtask

    task automatic set_in(input bit rdy, input bit bnd, input bit brk, input bit irq, input bit msk, input bit rq);
        ready = rdy; instructionBoundary = bnd; brkExecute = brk; irqN = irq; interruptMask = msk; resetRequest = rq;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_o), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        set_in(1, 0, 0, 1, 1, 0);
        nrst = 1'b1;
    endtask

    task automatic wait_step(input logic [2:0] s, input string name);
        int n = 0;
        while (sequenceStep !== s && n < 40) begin tick(); n++; end
        chk(name, 32'(sequenceStep), 32'(s));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sequenceActive !== 1'b0 && n < 40) begin tick(); n++; end
        chk(name, 32'(sequenceActive), 32'd0);
    endtask

    initial begin
        int n_act, n_done;
        for (int d = 1; d <= 2; d++) seq_steps.push_back(d);
        for (int s = 3; s <= 7; s++) seq_steps.push_back(s);
        set_in(1, 0, 0, 1, 1, 0);
        nmiN = 1'b1;
        #2;
        apply_reset();

        // Startup RESET entry, no boundary needed.
        for (int s = 1; s <= 7; s++) tbl.push_back(v(1,0,0,1,1,0, 3'(s),0,0,0));
        tbl.push_back(v(1,0,0,1,1,0, 0,0,0,1));
        tbl.push_back(v(1,0,0,1,1,0, 0,0,0,0));
        // IRQ launch; irqN released mid-sequence.
        tbl.push_back(v(1,1,0,0,0,0, 1,2,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 2,2,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 3,2,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 4,2,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 5,2,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 6,2,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 7,2,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 0,2,0,1));
        // Masked IRQ at a boundary stays idle.
        tbl.push_back(v(1,1,0,0,1,0, 0,2,0,0));
        tbl.push_back(v(1,1,0,0,1,0, 0,2,0,0));
        // BRK wins over a simultaneous IRQ.
        tbl.push_back(v(1,1,1,0,0,0, 1,3,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 2,3,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 3,3,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 4,3,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 5,3,1,0));
        tbl.push_back(v(1,0,0,1,0,0, 6,3,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 7,3,0,0));
        tbl.push_back(v(1,0,0,1,0,0, 0,3,0,1));
        foreach (tbl[i]) begin
            set_in(tbl[i].rdy, tbl[i].bnd, tbl[i].brk, tbl[i].irq, tbl[i].msk, tbl[i].rq);
            tick();
            chk($sformatf("table_%0d", i), {26'd0, sequenceStep, cause, writeCycle, sequenceDone},
                {26'd0, tbl[i].step, tbl[i].cause, tbl[i].wr, tbl[i].done});
        end

        // NMI edge during an IRQ entry: IRQ finishes, NMI follows at the next boundary, no retrigger.
        set_in(1, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 1, 0, 0); tick();
        nmiN = 1'b0;
        wait_step(3'd7, "irq_reaches_vec_hi");
        chk("irq_cause_kept", 32'(cause), 32'd2);
        tick();
        set_in(1, 1, 0, 1, 1, 0); tick();
        chk("nmi_launch", {30'd0, cause}, 32'd1);
        set_in(1, 0, 0, 1, 1, 0);
        wait_step(3'd6, "nmi_vec_lo");
        chk("nmi_vec_lo_sel", 32'(adlPresetSelect), 32'h01);
        tick();
        chk("nmi_vec_hi_sel", 32'(adlPresetSelect), 32'h02);
        wait_idle("nmi_done");
        tick();
        set_in(1, 1, 0, 1, 1, 0); tick(); tick();
        chk("nmi_no_retrigger", 32'(sequenceActive), 32'd0);
        nmiN = 1'b1;

        // Three-cycle stall at PUSH_PCL.
        set_in(1, 1, 0, 0, 0, 0); tick();
        n_act = int'(sequenceActive); n_done = 0;
        set_in(1, 0, 0, 1, 0, 0);
        repeat (3) begin tick(); n_act += int'(sequenceActive); end
        chk("stall_entry_step", 32'(sequenceStep), 32'd4);
        ready = 1'b0;
        repeat (3) begin tick(); n_act += int'(sequenceActive); chk("stall_hold", 32'(sequenceStep), 32'd4); end
        ready = 1'b1;
        tick(); n_act += int'(sequenceActive);
        chk("stall_resume", 32'(sequenceStep), 32'd5);
        repeat (6) begin tick(); n_act += int'(sequenceActive); n_done += int'(sequenceDone); end
        chk("stall_total_cycles", 32'(n_act), 32'd10);
        chk("stall_done_pulses", 32'(n_done), 32'd1);

        // resetRequest aborts an NMI entry at PUSH_PSR.
        nmiN = 1'b0;
        repeat (4) tick();
        set_in(1, 1, 0, 1, 1, 0); tick();
        chk("abort_nmi_launch", 32'(cause), 32'd1);
        set_in(1, 0, 0, 1, 1, 0);
        wait_step(3'd5, "abort_reach_psr");
        resetRequest = 1'b1; tick(); resetRequest = 1'b0;
        chk("abort_restart", {29'd0, sequenceStep, cause}, {29'd0, 3'd1, 2'd0});
        wait_step(3'd3, "abort_reach_pch");
        chk("abort_no_write", 32'(writeCycle), 32'd0);
        wait_idle("abort_done");
        nmiN = 1'b1;
        tick();

        // Async reset in the middle of an IRQ push.
        set_in(1, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 1, 0, 0);
        wait_step(3'd3, "areset_reach_pch");
        apply_reset();
        wait_idle("areset_startup_done");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            ready               = ($urandom_range(0, 9) != 0);
            instructionBoundary = ($urandom_range(0, 3) == 0);
            brkExecute          = ($urandom_range(0, 7) == 0);
            irqN                = 1'($urandom_range(0, 1));
            interruptMask       = 1'($urandom_range(0, 1));
            resetRequest        = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 29) == 0) nmiN = ~nmiN;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Control block that sequences the datapath through the 7-cycle RESET/NMI/IRQ/BRK entry: two dummy cycles, push PCH, push PCL, push PSR, fetch vector low, fetch vector high.
- Sits beside the instruction decoder. While active, its control strobes are OR'd into the datapath flag vector, and the decoder holds off.
- Owns interrupt prioritisation, NMI edge detection and IRQ masking.

Parameters:
- NMI_SYNC_STAGES, 2, synchroniser depth for nmiN before edge detection (min 2).
- DUMMY_CYCLES, 2, number of dummy-read cycles before the first push (1..2).

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- ready  in  1  datapath advance enable; state and outputs hold when 0
- instructionBoundary  in  1  decoder is at the last cycle of an instruction
- brkExecute  in  1  decoder has decoded BRK; valid with instructionBoundary
- irqN  in  1  level-sensitive IRQ, active low
- nmiN  in  1  asynchronous NMI pin, falling edge triggers
- resetRequest  in  1  synchronous soft reset request, level
- interruptMask  in  1  PSR I flag
- sequenceActive  out  1  sequencer owns the datapath
- sequenceStep  out  3  0=IDLE, 1..2 DUMMY, 3=PUSH_PCH, 4=PUSH_PCL, 5=PUSH_PSR, 6=VEC_LO, 7=VEC_HI
- cause  out  2  0=RESET, 1=NMI, 2=IRQ, 3=BRK
- adhStackPage  out  1  ADH preset 0x01, asserted in push states
- adlFromSp  out  1  SP drives ADL, asserted in push states
- spDecrement  out  1  SP decrement in push states
- pushSource  out  2  0=PCH, 1=PCL, 2=PSR (DB source for DOR)
- writeCycle  out  1  external write; forced 0 when cause=RESET
- adlPresetSelect  out  6  one-hot {FF,FE,FD,FC,FB,FA}, valid in VEC states
- adhHigh  out  1  ADH preset 0xFF, asserted in VEC states
- loadPcl  out  1  data to PCL, asserted in VEC_LO
- loadPch  out  1  data to PCH, asserted in VEC_HI
- setInterruptFlag  out  1  set PSR I, asserted in VEC_LO
- breakBitHigh  out  1  pushed PSR has B=1; PUSH_PSR with cause=BRK only
- sequenceDone  out  1  one-cycle pulse on VEC_HI exit

Behaviour:
- Reset (nrst low, async):
  - State goes to IDLE, resetPending=1, nmiPending=0, synchroniser flops=1.
  - All outputs are 0, except cause=0.
- Startup: on the first clk with nrst high and ready=1, IDLE goes to DUMMY0 with cause=RESET, without waiting for instructionBoundary.
- NMI detection:
  - nmiN passes through NMI_SYNC_STAGES flops.
  - A synchronised 1→0 transition sets nmiPending.
  - nmiPending is cleared only when an NMI sequence is launched.
  - An edge during any active sequence stays pending.
  - A held-low nmiN does not retrigger.
- Launch: from IDLE when ready=1 and either resetPending or instructionBoundary=1. Priority:
  - resetPending or resetRequest → RESET
  - else nmiPending → NMI
  - else brkExecute → BRK
  - else irqN=0 and interruptMask=0 → IRQ
  - else stay IDLE
- Cause register: latched at launch, constant for the whole sequence.
- Progression:
  - DUMMY0 → (DUMMY1 if DUMMY_CYCLES=2) → PUSH_PCH → PUSH_PCL → PUSH_PSR → VEC_LO → VEC_HI → IDLE.
  - One step per cycle with ready=1. Total length is 5+DUMMY_CYCLES cycles.
- Stall: ready=0 freezes state and all outputs. sequenceDone is not re-pulsed.
- RESET sequence: push states perform SP decrement and address generation with writeCycle=0 (reads only). resetPending is cleared on VEC_HI exit.
- Vector select:
  - VEC_LO: RESET=FC, NMI=FA, IRQ/BRK=FE.
  - VEC_HI: RESET=FD, NMI=FB, IRQ/BRK=FF.
- resetRequest while active: aborts the current sequence. Next cycle is DUMMY0 with cause=RESET. A pending NMI remains pending.
- IRQ deasserted mid-sequence: no effect; the sequence completes.
- sequenceActive: equals (state≠IDLE), registered.
- Output timing: all control outputs decode registered state only, with no combinational input-to-output paths.

Test Plan:
- nrst release, ready=1 → sequenceStep 1..7 over 7 cycles; cause=0; writeCycle=0 throughout; adlPresetSelect=FC then FD; loadPcl at step 6, loadPch at step 7; sequenceDone pulse; then IDLE.
- IRQ low, interruptMask=0, boundary pulse → cause=2; writeCycle=1 at steps 3/4/5 with pushSource 0/1/2; breakBitHigh=0; FE/FF vectors; setInterruptFlag at step 6. Repeat with interruptMask=1 → stays IDLE.
- brkExecute and irqN low together at boundary → cause=3; breakBitHigh=1 only at step 5.
- nmiN falls during an IRQ sequence → IRQ completes; next boundary launches cause=1 with vectors FA/FB. nmiN held low afterwards → no second NMI.
- ready=0 for 3 cycles at step 4 → step and outputs frozen; resumes at step 5; total 10 cycles; single sequenceDone.
- resetRequest at step 5 of NMI → next step=1, cause=0, writeCycle=0. Async nrst low at step 3 → outputs 0 immediately.
